ccip_req_rsp_tracker: RTL and testbench
=======================================

// Module: ccip_req_rsp_tracker
// PURPOSE
//  Observes CCI-P TX requests and RX responses on c0/c1 and keeps registered counts of
//  in-flight read lines, write lines and write fences. Drives almost-full back-pressure,
//  sticky protocol-error flags and a drain/quiesce handshake.
//  Sits passively beside the AFU-side CCI-P port; it never modifies traffic.
// PARAMETERS
//  MAX_ACTIVE_RD   512  max in-flight read lines; count width CNT_W = $clog2(max(MAX_ACTIVE_RD,MAX_ACTIVE_WR)+1)
//  MAX_ACTIVE_WR   512  max in-flight write lines
//  RD_AF_THRESH    448  c0_almost_full asserts when rd count >= this
//  WR_AF_THRESH    448  c1_almost_full asserts when wr count >= this
//  MAX_FENCES      15   max in-flight write fences; fence count width $clog2(MAX_FENCES+1)
// PORTS
//  clk             in   1          clock
//  reset           in   1          synchronous, active-high reset
//  c0Tx            in   t_if_ccip_c0_Tx  observed read requests
//  c1Tx            in   t_if_ccip_c1_Tx  observed write/fence requests (one beat per line)
//  c0Rx            in   t_if_ccip_c0_Rx  observed read responses (MMIO ignored)
//  c1Rx            in   t_if_ccip_c1_Rx  observed write/fence responses
//  drain_req       in   1          level; request quiesce
//  rd_active       out  CNT_W      in-flight read lines
//  wr_active       out  CNT_W      in-flight write lines
//  fence_active    out  FW         in-flight fences
//  c0_almost_full  out  1          rd_active >= RD_AF_THRESH
//  c1_almost_full  out  1          wr_active >= WR_AF_THRESH
//  idle            out  1          all three counts zero
//  drain_done      out  1          high in DRAINED state
//  err_underflow   out  1          sticky: response with no matching outstanding count
//  err_overflow    out  1          sticky: count exceeded its MAX
//  err_drain       out  1          sticky: new request issued while draining
// BEHAVIOUR
//  - All outputs registered. Reset: counts 0, almost_fulls 0, idle 1, drain_done 0, errors 0, FSM=RUN.
//  - Latency: one cycle from any qualifying input to updated count and derived flags.
//  - rd add (c0Tx.valid, RDLINE_S/I): cl_len+1 lines (eCL_LEN_1/2/4 -> 1/2/4).
//    rd sub (c0Rx.rspValid and resp_type eRSP_RDLINE): 1 line.
//  - wr add (c1Tx.valid, any write type except eREQ_WRFENCE): 1 line per beat.
//    wr sub (c1Rx rspValid and eRSP_WRLINE): hdr.format ? cl_num+1 : 1.
//  - fence add: c1Tx eREQ_WRFENCE. fence sub: c1Rx eRSP_WRFENCE.
//  - Same-cycle add and sub on a counter: next = cur + add - sub, computed at CNT_W+1 bits.
//  - Underflow (cur + add < sub): counter clamps to 0; err_underflow set.
//    Overflow (result > MAX): counter clamps to MAX; err_overflow set.
//  - Errors clear only on reset.
//  - Flags compare against the next count values, so they take effect in the same cycle as the counts.
//  - FSM:
//    - RUN -> DRAIN_WAIT when drain_req=1.
//    - DRAIN_WAIT -> DRAINED when all next counts are 0. If already idle, this takes the cycle after entry.
//    - DRAINED -> RUN when drain_req=0.
//    - DRAIN_WAIT -> RUN when drain_req=0 (abort; no drain_done).
//    - DRAINED: drain_done=1.
//    - Any add in DRAIN_WAIT or DRAINED sets err_drain; the count still updates. An add in DRAINED also returns the FSM to DRAIN_WAIT.
//  - reset asserted mid-operation: all state returns to reset values next cycle; in-flight traffic is forgotten.
// TESTING
//  1. Reset, no traffic -> counts 0, idle=1, all error flags 0.
//  2. One c0 read cl_len=eCL_LEN_4, then 4 rdline rsps -> rd_active 4,3,2,1,0; idle=1 one cycle after the last rsp.
//  3. 4 write beats, then 1 packed rsp (format=1, cl_num=3) -> wr_active 4 then 0.
//     Same-cycle write beat + 1-line rsp at wr_active=2 -> stays 2.
//  4. Ramp reads to RD_AF_THRESH=448 -> c0_almost_full=1 exactly when rd_active=448; falls at 447.
//  5. wr_active=3, drain_req=1 -> DRAIN_WAIT; 3 rsps -> drain_done=1 next cycle; drain_req=0 -> drain_done=0.
//     Write during DRAINED -> err_drain=1.
//  6. rd rsp at rd_active=0 -> err_underflow=1, rd_active stays 0.
//     Fence then eRSP_WRFENCE -> fence_active 1 then 0.

Source files
------------

// File: rtl/ccip_req_rsp_tracker.sv
// CCI-P request/response tracker.
// Passively watches the AFU-side CCI-P channels and keeps registered counts of
// in-flight read lines, write lines and write fences. From those counts it
// derives almost-full back-pressure, sticky protocol-error flags and a
// drain/quiesce handshake. Traffic on the port is never modified.

package ccip_if_pkg;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic [1:0]   vc_sel;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [1:0]   vc_sel;
    logic         sop;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         hit_miss;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         hit_miss;
    logic         format;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

endpackage

module ccip_req_rsp_tracker
  import ccip_if_pkg::*;
#(
  parameter int MAX_ACTIVE_RD = 512,
  parameter int MAX_ACTIVE_WR = 512,
  parameter int RD_AF_THRESH  = 448,
  parameter int WR_AF_THRESH  = 448,
  parameter int MAX_FENCES    = 15,
  localparam int CNT_W = $clog2(((MAX_ACTIVE_RD > MAX_ACTIVE_WR) ? MAX_ACTIVE_RD : MAX_ACTIVE_WR) + 1),
  localparam int FW    = $clog2(MAX_FENCES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  t_if_ccip_c0_Tx   c0Tx,
  input  t_if_ccip_c1_Tx   c1Tx,
  input  t_if_ccip_c0_Rx   c0Rx,
  input  t_if_ccip_c1_Rx   c1Rx,
  input  logic             drain_req,
  output logic [CNT_W-1:0] rd_active,
  output logic [CNT_W-1:0] wr_active,
  output logic [FW-1:0]    fence_active,
  output logic             c0_almost_full,
  output logic             c1_almost_full,
  output logic             idle,
  output logic             drain_done,
  output logic             err_underflow,
  output logic             err_overflow,
  output logic             err_drain
);

  // Arithmetic width: one bit above the widest counter so cur + add never wraps.
  localparam int EW = ((CNT_W > FW) ? CNT_W : FW) + 1;

  typedef struct packed {
    logic          under;
    logic          over;
    logic [EW-1:0] val;
  } t_step;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DRAIN_WAIT = 2'd1,
    DRAINED    = 2'd2
  } t_state;

  t_state state;
  t_state state_next;

  logic [EW-1:0] rd_add;
  logic [EW-1:0] rd_sub;
  logic [EW-1:0] wr_add;
  logic [EW-1:0] wr_sub;
  logic [EW-1:0] fence_add;
  logic [EW-1:0] fence_sub;
  t_step         rd_step;
  t_step         wr_step;
  t_step         fence_step;
  logic          any_add;
  logic          next_all_zero;

  // Combined add/sub with clamping: underflow pins to zero, overflow pins to the limit.
  function automatic t_step count_step(input logic [EW-1:0] cur,
                                       input logic [EW-1:0] add,
                                       input logic [EW-1:0] sub,
                                       input logic [EW-1:0] lim);
    t_step         r;
    logic [EW-1:0] sum;
    sum     = cur + add;
    r.under = 1'b0;
    r.over  = 1'b0;
    r.val   = sum - sub;
    if (sum < sub) begin
      r.under = 1'b1;
      r.val   = '0;
    end else if (r.val > lim) begin
      r.over = 1'b1;
      r.val  = lim;
    end
    return r;
  endfunction

  // Decode how many lines/fences each channel adds or retires this cycle.
  always_comb begin
    rd_add    = '0;
    rd_sub    = '0;
    wr_add    = '0;
    wr_sub    = '0;
    fence_add = '0;
    fence_sub = '0;
    if (c0Tx.valid && (c0Tx.hdr.req_type == eREQ_RDLINE_S || c0Tx.hdr.req_type == eREQ_RDLINE_I))
      rd_add = EW'(c0Tx.hdr.cl_len) + EW'(1);
    if (c0Rx.rspValid && c0Rx.hdr.resp_type == eRSP_RDLINE)
      rd_sub = EW'(1);
    if (c1Tx.valid && c1Tx.hdr.req_type != eREQ_WRFENCE)
      wr_add = EW'(1);
    if (c1Tx.valid && c1Tx.hdr.req_type == eREQ_WRFENCE)
      fence_add = EW'(1);
    if (c1Rx.rspValid && c1Rx.hdr.resp_type == eRSP_WRLINE)
      wr_sub = c1Rx.hdr.format ? (EW'(c1Rx.hdr.cl_num) + EW'(1)) : EW'(1);
    if (c1Rx.rspValid && c1Rx.hdr.resp_type == eRSP_WRFENCE)
      fence_sub = EW'(1);
  end

  // Next count values, shared by the count registers, the flags and the FSM.
  always_comb begin
    rd_step       = count_step(EW'(rd_active), rd_add, rd_sub, EW'(MAX_ACTIVE_RD));
    wr_step       = count_step(EW'(wr_active), wr_add, wr_sub, EW'(MAX_ACTIVE_WR));
    fence_step    = count_step(EW'(fence_active), fence_add, fence_sub, EW'(MAX_FENCES));
    any_add       = (rd_add != '0) || (wr_add != '0) || (fence_add != '0);
    next_all_zero = (rd_step.val == '0) && (wr_step.val == '0) && (fence_step.val == '0);
  end

  // Count registers, derived flags and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_active      <= '0;
      wr_active      <= '0;
      fence_active   <= '0;
      c0_almost_full <= 1'b0;
      c1_almost_full <= 1'b0;
      idle           <= 1'b1;
      err_underflow  <= 1'b0;
      err_overflow   <= 1'b0;
      err_drain      <= 1'b0;
    end else begin
      rd_active      <= rd_step.val[CNT_W-1:0];
      wr_active      <= wr_step.val[CNT_W-1:0];
      fence_active   <= fence_step.val[FW-1:0];
      c0_almost_full <= rd_step.val >= EW'(RD_AF_THRESH);
      c1_almost_full <= wr_step.val >= EW'(WR_AF_THRESH);
      idle           <= next_all_zero;
      err_underflow  <= err_underflow | rd_step.under | wr_step.under | fence_step.under;
      err_overflow   <= err_overflow | rd_step.over | wr_step.over | fence_step.over;
      err_drain      <= err_drain | (any_add && state != RUN);
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Drain FSM transitions; dropping drain_req always returns to RUN.
  always_comb begin
    state_next = state;
    case (state)
      RUN:        if (drain_req) state_next = DRAIN_WAIT;
      DRAIN_WAIT: begin
        if (!drain_req)         state_next = RUN;
        else if (next_all_zero) state_next = DRAINED;
      end
      DRAINED: begin
        if (!drain_req)   state_next = RUN;
        else if (any_add) state_next = DRAIN_WAIT;
      end
      default:    state_next = RUN;
    endcase
  end

  // Drain FSM outputs, decoded straight from the state register.
  always_comb begin
    drain_done = (state == DRAINED);
  end

  // Header, payload and upper arithmetic bits the tracker does not need.
  logic unused_bits;
  assign unused_bits = ^{c0Tx, c1Tx, c0Rx, c1Rx, rd_step, wr_step, fence_step};

endmodule

// File: tb/tb_ccip_req_rsp_tracker.sv
// Directed testbench for ccip_req_rsp_tracker with hand-computed expectations.

module tb_ccip_req_rsp_tracker;
  import ccip_if_pkg::*;

  localparam int CNT_W = 10;
  localparam int FW    = 4;

  logic           clk;
  logic           reset;
  t_if_ccip_c0_Tx c0Tx;
  t_if_ccip_c1_Tx c1Tx;
  t_if_ccip_c0_Rx c0Rx;
  t_if_ccip_c1_Rx c1Rx;
  logic           drain_req;
  logic [CNT_W-1:0] rd_active;
  logic [CNT_W-1:0] wr_active;
  logic [FW-1:0]    fence_active;
  logic           c0_almost_full;
  logic           c1_almost_full;
  logic           idle;
  logic           drain_done;
  logic           err_underflow;
  logic           err_overflow;
  logic           err_drain;

  int vector_count;
  int miss_count;

  ccip_req_rsp_tracker dut (
    .clk            (clk),
    .reset          (reset),
    .c0Tx           (c0Tx),
    .c1Tx           (c1Tx),
    .c0Rx           (c0Rx),
    .c1Rx           (c1Rx),
    .drain_req      (drain_req),
    .rd_active      (rd_active),
    .wr_active      (wr_active),
    .fence_active   (fence_active),
    .c0_almost_full (c0_almost_full),
    .c1_almost_full (c1_almost_full),
    .idle           (idle),
    .drain_done     (drain_done),
    .err_underflow  (err_underflow),
    .err_overflow   (err_overflow),
    .err_drain      (err_drain)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clear_traffic();
    c0Tx = '0;
    c1Tx = '0;
    c0Rx = '0;
    c1Rx = '0;
  endtask

  // Holds the currently set traffic for one clock, then clears it; outputs are settled on return.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clear_traffic();
  endtask

  task automatic set_rd_req(input t_ccip_clLen len);
    c0Tx.valid        = 1'b1;
    c0Tx.hdr.req_type = eREQ_RDLINE_S;
    c0Tx.hdr.cl_len   = len;
  endtask

  task automatic set_rd_rsp();
    c0Rx.rspValid      = 1'b1;
    c0Rx.hdr.resp_type = eRSP_RDLINE;
  endtask

  task automatic set_wr_beat();
    c1Tx.valid        = 1'b1;
    c1Tx.hdr.req_type = eREQ_WRLINE_I;
  endtask

  task automatic set_wr_rsp(input logic format, input logic [1:0] cl_num);
    c1Rx.rspValid      = 1'b1;
    c1Rx.hdr.resp_type = eRSP_WRLINE;
    c1Rx.hdr.format    = format;
    c1Rx.hdr.cl_num    = cl_num;
  endtask

  task automatic set_fence_req();
    c1Tx.valid        = 1'b1;
    c1Tx.hdr.req_type = eREQ_WRFENCE;
  endtask

  task automatic set_fence_rsp();
    c1Rx.rspValid      = 1'b1;
    c1Rx.hdr.resp_type = eRSP_WRFENCE;
  endtask

  initial begin
    vector_count = 0;
    miss_count   = 0;
    reset        = 1'b1;
    drain_req    = 1'b0;
    clear_traffic();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state with no traffic.
    applyStimulus();
    checkOutput("reset_rd", rd_active, 0);
    checkOutput("reset_wr", wr_active, 0);
    checkOutput("reset_fence", fence_active, 0);
    checkOutput("reset_idle", idle, 1);
    checkOutput("reset_af", {c0_almost_full, c1_almost_full}, 0);
    checkOutput("reset_errs", {err_underflow, err_overflow, err_drain}, 0);
    checkOutput("reset_drain_done", drain_done, 0);

    // Four-line read then four single-line responses.
    set_rd_req(eCL_LEN_4);
    applyStimulus();
    checkOutput("rd4_add", rd_active, 4);
    checkOutput("rd4_idle", idle, 0);
    for (int i = 3; i >= 0; i--) begin
      set_rd_rsp();
      applyStimulus();
      checkOutput("rd4_sub", rd_active, i);
    end
    checkOutput("rd4_idle_after", idle, 1);

    // Four write beats then one packed response.
    for (int i = 1; i <= 4; i++) begin
      set_wr_beat();
      applyStimulus();
    end
    checkOutput("wr4_add", wr_active, 4);
    set_wr_rsp(1'b1, 2'd3);
    applyStimulus();
    checkOutput("wr_packed_rsp", wr_active, 0);

    // Same-cycle beat and response at wr_active=2.
    set_wr_beat();
    applyStimulus();
    set_wr_beat();
    applyStimulus();
    checkOutput("wr_two", wr_active, 2);
    set_wr_beat();
    set_wr_rsp(1'b0, 2'd3);
    applyStimulus();
    checkOutput("wr_same_cycle", wr_active, 2);
    checkOutput("wr_same_cycle_err", {err_underflow, err_overflow}, 0);

    // Drain with three writes outstanding.
    set_wr_beat();
    applyStimulus();
    checkOutput("drain_start_wr", wr_active, 3);
    drain_req = 1'b1;
    applyStimulus();
    checkOutput("drain_wait_done", drain_done, 0);
    for (int i = 2; i >= 0; i--) begin
      set_wr_rsp(1'b0, 2'd0);
      applyStimulus();
      checkOutput("drain_wr", wr_active, i);
      checkOutput("drain_done_track", drain_done, (i == 0) ? 1 : 0);
    end
    drain_req = 1'b0;
    applyStimulus();
    checkOutput("drain_release", drain_done, 0);

    // Re-drain while already idle, then issue a write while drained.
    drain_req = 1'b1;
    applyStimulus();
    checkOutput("redrain_entry", drain_done, 0);
    applyStimulus();
    checkOutput("redrain_done", drain_done, 1);
    checkOutput("redrain_no_err", err_drain, 0);
    set_wr_beat();
    applyStimulus();
    checkOutput("drained_write_err", err_drain, 1);
    checkOutput("drained_write_wr", wr_active, 1);
    checkOutput("drained_write_done", drain_done, 0);
    drain_req = 1'b0;
    applyStimulus();
    set_wr_rsp(1'b0, 2'd0);
    applyStimulus();
    checkOutput("drained_cleanup_wr", wr_active, 0);
    checkOutput("err_drain_sticky", err_drain, 1);

    // Read ramp around the almost-full threshold.
    for (int i = 0; i < 111; i++) begin
      set_rd_req(eCL_LEN_4);
      applyStimulus();
    end
    checkOutput("ramp_444", rd_active, 444);
    checkOutput("ramp_444_af", c0_almost_full, 0);
    set_rd_req(eCL_LEN_2);
    applyStimulus();
    set_rd_req(eCL_LEN_1);
    applyStimulus();
    checkOutput("ramp_447", rd_active, 447);
    checkOutput("ramp_447_af", c0_almost_full, 0);
    set_rd_req(eCL_LEN_1);
    applyStimulus();
    checkOutput("ramp_448", rd_active, 448);
    checkOutput("ramp_448_af", c0_almost_full, 1);
    checkOutput("ramp_c1_af", c1_almost_full, 0);
    set_rd_rsp();
    applyStimulus();
    checkOutput("fall_447_af", c0_almost_full, 0);
    set_rd_req(eCL_LEN_1);
    set_rd_rsp();
    applyStimulus();
    checkOutput("rd_same_cycle", rd_active, 447);
    set_rd_req(eCL_LEN_1);
    applyStimulus();
    checkOutput("rise_448_af", c0_almost_full, 1);

    // Fill to the maximum, then overflow.
    for (int i = 0; i < 16; i++) begin
      set_rd_req(eCL_LEN_4);
      applyStimulus();
    end
    checkOutput("rd_max", rd_active, 512);
    checkOutput("rd_max_no_ovf", err_overflow, 0);
    set_rd_req(eCL_LEN_1);
    applyStimulus();
    checkOutput("rd_ovf_clamp", rd_active, 512);
    checkOutput("rd_ovf_err", err_overflow, 1);

    // Drain reads back to zero.
    for (int i = 0; i < 512; i++) begin
      set_rd_rsp();
      applyStimulus();
    end
    checkOutput("rd_drained", rd_active, 0);
    checkOutput("rd_drained_af", c0_almost_full, 0);
    checkOutput("no_underflow_yet", err_underflow, 0);

    // MMIO reads on c0Rx are ignored.
    c0Rx.mmioRdValid = 1'b1;
    applyStimulus();
    checkOutput("mmio_ignored_rd", rd_active, 0);
    checkOutput("mmio_ignored_err", err_underflow, 0);

    // Read response with nothing outstanding.
    set_rd_rsp();
    applyStimulus();
    checkOutput("underflow_rd", rd_active, 0);
    checkOutput("underflow_err", err_underflow, 1);

    // Fence then fence response.
    set_fence_req();
    applyStimulus();
    checkOutput("fence_add", fence_active, 1);
    checkOutput("fence_wr_untouched", wr_active, 0);
    checkOutput("fence_idle", idle, 0);
    set_fence_rsp();
    applyStimulus();
    checkOutput("fence_sub", fence_active, 0);
    checkOutput("fence_idle_after", idle, 1);

    // Drain aborted before completion never reports done.
    set_wr_beat();
    applyStimulus();
    drain_req = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("abort_wait", drain_done, 0);
    drain_req = 1'b0;
    set_wr_rsp(1'b0, 2'd0);
    applyStimulus();
    checkOutput("abort_wr", wr_active, 0);
    applyStimulus();
    checkOutput("abort_no_done", drain_done, 0);

    // Reset mid-operation forgets traffic and clears errors.
    set_rd_req(eCL_LEN_2);
    applyStimulus();
    checkOutput("pre_reset_rd", rd_active, 2);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("midreset_rd", rd_active, 0);
    checkOutput("midreset_idle", idle, 1);
    checkOutput("midreset_errs", {err_underflow, err_overflow, err_drain}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
